// File: rtl/alu_bist.sv
// Built-in self test for the execute-stage ALU: LFSR-driven operands,
// a fixed walk through every opcode, and a MISR signature checked against a golden value.
module alu_bist #(
  parameter int unsigned NUM_VECTORS = 16,
  parameter logic [31:0] LFSR_SEED   = 32'hACE1_2468,
  parameter logic [31:0] GOLDEN_SIG  = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  output logic [31:0] o_operand_a,
  output logic [31:0] o_operand_b,
  output logic [3:0]  o_alu_op,
  input  logic [31:0] i_alu_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_pass,
  output logic [31:0] o_signature
);

  localparam int unsigned VW = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
  localparam logic [VW-1:0] VEC_LAST = VW'(NUM_VECTORS - 1);
  localparam logic [3:0] OP_LAST = 4'd10;
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] MISR_INIT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    APPLY,
    SAMPLE,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [31:0]   lfsr_q, lfsr_d;
  logic [31:0]   misr_q, misr_d;
  logic [3:0]    op_idx_q, op_idx_d;
  logic [VW-1:0] vec_q, vec_d;
  logic [31:0]   op_a_q, op_a_d;
  logic [31:0]   op_b_q, op_b_d;
  logic [3:0]    alu_op_q, alu_op_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;

  logic [31:0]   lfsr_next;
  logic [31:0]   misr_shift;
  logic [31:0]   misr_next;

  // Opcode walk order; any index past the table maps to a harmless ADD.
  function automatic logic [3:0] op_lut(input logic [3:0] idx);
    logic [3:0] op;
    unique case (idx)
      4'd0:    op = 4'b0000;
      4'd1:    op = 4'b1000;
      4'd2:    op = 4'b0001;
      4'd3:    op = 4'b0010;
      4'd4:    op = 4'b0011;
      4'd5:    op = 4'b0100;
      4'd6:    op = 4'b0101;
      4'd7:    op = 4'b1101;
      4'd8:    op = 4'b0110;
      4'd9:    op = 4'b0111;
      4'd10:   op = 4'b1111;
      default: op = 4'b0000;
    endcase
    return op;
  endfunction

  always_comb begin
    lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK)
                          : (lfsr_q >> 1);
    misr_shift = misr_q[31] ? ((misr_q << 1) ^ MISR_POLY)
                            : (misr_q << 1);
    misr_next = misr_shift ^ i_alu_data;
  end

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    misr_d   = misr_q;
    op_idx_d = op_idx_q;
    vec_d    = vec_q;
    done_d   = done_q;
    pass_d   = pass_q;
    op_a_d   = 32'd0;
    op_b_d   = 32'd0;
    alu_op_d = 4'b0000;
    busy_d   = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (i_start) begin
          state_d = SEED;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      SEED: begin
        lfsr_d   = LFSR_SEED;
        misr_d   = MISR_INIT;
        op_idx_d = 4'd0;
        vec_d    = '0;
        state_d  = APPLY;
      end
      APPLY: begin
        state_d = SAMPLE;
      end
      SAMPLE: begin
        misr_d = misr_next;
        lfsr_d = lfsr_next;
        if (vec_q == VEC_LAST) begin
          vec_d = '0;
          if (op_idx_q == OP_LAST) begin
            state_d = DONE;
            done_d  = 1'b1;
            pass_d  = (misr_next == GOLDEN_SIG);
          end else begin
            op_idx_d = op_idx_q + 4'd1;
            state_d  = APPLY;
          end
        end else begin
          vec_d   = vec_q + VW'(1);
          state_d = APPLY;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    if (state_d == APPLY || state_d == SAMPLE) begin
      op_a_d   = lfsr_d;
      op_b_d   = {lfsr_d[15:0], lfsr_d[31:16]};
      alu_op_d = op_lut(op_idx_d);
    end
    busy_d = (state_d == SEED) || (state_d == APPLY) || (state_d == SAMPLE);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= IDLE;
      lfsr_q   <= LFSR_SEED;
      misr_q   <= MISR_INIT;
      op_idx_q <= 4'd0;
      vec_q    <= '0;
      op_a_q   <= 32'd0;
      op_b_q   <= 32'd0;
      alu_op_q <= 4'b0000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      misr_q   <= misr_d;
      op_idx_q <= op_idx_d;
      vec_q    <= vec_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      alu_op_q <= alu_op_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign o_operand_a = op_a_q;
  assign o_operand_b = op_b_q;
  assign o_alu_op    = alu_op_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_pass      = pass_q;
  assign o_signature = misr_q;

endmodule

// File: tb/tb_alu_bist.sv
// Directed bench for alu_bist: one instance with a single vector per opcode
// for timing checks, one with sixteen vectors and a model-derived golden signature.
module tb_alu_bist;

  localparam logic [31:0] SEED = 32'hACE1_2468;

  function automatic logic [3:0] op_at(input int i);
    logic [3:0] r;
    case (i)
      0:       r = 4'b0000;
      1:       r = 4'b1000;
      2:       r = 4'b0001;
      3:       r = 4'b0010;
      4:       r = 4'b0011;
      5:       r = 4'b0100;
      6:       r = 4'b0101;
      7:       r = 4'b1101;
      8:       r = 4'b0110;
      9:       r = 4'b0111;
      10:      r = 4'b1111;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  // Reference ALU; flt forces OR result bit 7 to zero.
  function automatic logic [31:0] alu_f(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [3:0]  op,
                                        input bit          flt);
    logic [31:0] r;
    case (op)
      4'b0000: r = a + b;
      4'b1000: r = a - b;
      4'b0001: r = a << b[4:0];
      4'b0010: r = {31'd0, $signed(a) < $signed(b)};
      4'b0011: r = {31'd0, a < b};
      4'b0100: r = a ^ b;
      4'b0101: r = a >> b[4:0];
      4'b1101: r = 32'($signed(a) >>> b[4:0]);
      4'b0110: r = flt ? ((a | b) & 32'hFFFF_FF7F) : (a | b);
      4'b0111: r = a & b;
      4'b1111: r = b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] model_sig(input int nv, input bit flt);
    logic [31:0] lfsr;
    logic [31:0] sig;
    logic [31:0] t;
    logic [31:0] d;
    lfsr = SEED;
    sig  = 32'hFFFF_FFFF;
    for (int o = 0; o < 11; o++) begin
      for (int v = 0; v < nv; v++) begin
        d = alu_f(lfsr, {lfsr[15:0], lfsr[31:16]}, op_at(o), flt);
        t = sig[31] ? ((sig << 1) ^ 32'h04C1_1DB7) : (sig << 1);
        sig = t ^ d;
        lfsr = lfsr[0] ? ((lfsr >> 1) ^ 32'h8020_0003) : (lfsr >> 1);
      end
    end
    return sig;
  endfunction

  localparam logic [31:0] G16 = model_sig(16, 1'b0);

  logic        clk;
  logic        rst;
  logic        fault;
  logic        s1, s16;
  logic [31:0] a1, b1, d1, sig1;
  logic [3:0]  op1;
  logic        busy1, done1, pass1;
  logic [31:0] a16, b16, d16, sig16;
  logic [3:0]  op16;
  logic        busy16, done16, pass16;

  int checks;
  int errs;

  assign d1  = alu_f(a1, b1, op1, fault);
  assign d16 = alu_f(a16, b16, op16, fault);

  alu_bist #(.NUM_VECTORS(1)) u1 (
    .i_clk(clk), .i_reset(rst), .i_start(s1),
    .o_operand_a(a1), .o_operand_b(b1), .o_alu_op(op1),
    .i_alu_data(d1), .o_busy(busy1), .o_done(done1),
    .o_pass(pass1), .o_signature(sig1)
  );

  alu_bist #(.NUM_VECTORS(16), .GOLDEN_SIG(G16)) u16 (
    .i_clk(clk), .i_reset(rst), .i_start(s16),
    .o_operand_a(a16), .o_operand_b(b16), .o_alu_op(op16),
    .i_alu_data(d16), .o_busy(busy16), .o_done(done16),
    .o_pass(pass16), .o_signature(sig16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit big);
    @(negedge clk);
    if (big) s16 = 1'b1;
    else s1 = 1'b1;
    tick();
    s1  = 1'b0;
    s16 = 1'b0;
  endtask

  task automatic wait_done(input bit big, input int max, output int n);
    logic dn;
    n  = 0;
    dn = 1'b0;
    while (n < max && !dn) begin
      tick();
      n++;
      dn = big ? done16 : done1;
    end
    chk("done_seen", 32'(dn), 32'd1);
  endtask

  logic [31:0] m1, m16, mf, first16;
  logic early;
  int n;

  initial begin
    rst = 1'b1; s1 = 1'b0; s16 = 1'b0; fault = 1'b0;
    checks = 0; errs = 0;
    m1  = model_sig(1, 1'b0);
    m16 = model_sig(16, 1'b0);
    mf  = model_sig(16, 1'b1);
    repeat (3) tick();
    @(negedge clk) rst = 1'b0;

    // asynchronous reset while a run is active
    pulse(1'b0);
    repeat (4) tick();
    chk("pre_rst_busy", 32'(busy1), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_pass", 32'(pass1), 32'd0);
    chk("rst_sig", sig1, 32'hFFFF_FFFF);
    chk("rst_a", a1, 32'd0);
    chk("rst_b", b1, 32'd0);
    chk("rst_op", 32'(op1), 32'd0);
    @(negedge clk) rst = 1'b0;

    // single-vector run: opcode walk, operands, latency
    pulse(1'b0);
    for (int k = 1; k <= 23; k++) begin
      tick();
      if (k <= 22) begin
        chk("walk_op", 32'(op1), 32'(op_at((k - 1) / 2)));
        chk("walk_busy", 32'(busy1), 32'd1);
        chk("walk_done", 32'(done1), 32'd0);
      end
      if (k == 1) begin
        chk("v0_a", a1, 32'hACE1_2468);
        chk("v0_b", b1, 32'h2468_ACE1);
      end
      if (k == 3) begin
        chk("v1_a", a1, 32'h5670_9234);
        chk("v1_b", b1, 32'h9234_5670);
      end
    end
    chk("run1_done", 32'(done1), 32'd1);
    chk("run1_busy", 32'(busy1), 32'd0);
    chk("run1_a", a1, 32'd0);
    chk("run1_op", 32'(op1), 32'd0);
    chk("run1_sig", sig1, m1);
    chk("run1_pass", 32'(pass1), 32'(m1 == 32'd0));
    tick();
    chk("sig_frozen", sig1, m1);

    // start held high for a whole run
    @(negedge clk) s1 = 1'b1;
    tick();
    early = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      tick();
      early = early | done1;
    end
    chk("hold_early", 32'(early), 32'd0);
    tick();
    chk("hold_done", 32'(done1), 32'd1);
    tick();
    chk("hold_restart_done", 32'(done1), 32'd0);
    chk("hold_restart_busy", 32'(busy1), 32'd1);
    @(negedge clk) s1 = 1'b0;
    wait_done(1'b0, 40, n);
    chk("hold_len", 32'(n), 32'd23);
    chk("hold_sig", sig1, m1);

    // reset during the SAMPLE of opcode 0101, then a fresh run
    pulse(1'b0);
    repeat (14) tick();
    chk("abort_op", 32'(op1), 32'b0101);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("abort_done", 32'(done1), 32'd0);
    chk("abort_busy", 32'(busy1), 32'd0);
    @(negedge clk) rst = 1'b0;
    tick();
    chk("abort_idle_done", 32'(done1), 32'd0);
    pulse(1'b0);
    wait_done(1'b0, 40, n);
    chk("fresh_len", 32'(n), 32'd23);
    chk("fresh_sig", sig1, m1);

    // sixteen vectors against the model golden signature
    pulse(1'b1);
    wait_done(1'b1, 400, n);
    chk("nv16_len", 32'(n), 32'd353);
    chk("nv16_sig", sig16, m16);
    chk("nv16_pass", 32'(pass16), 32'd1);
    first16 = sig16;

    pulse(1'b1);
    chk("b2b_clear", 32'(done16), 32'd0);
    wait_done(1'b1, 400, n);
    chk("b2b_sig", sig16, first16);
    chk("b2b_pass", 32'(pass16), 32'd1);

    // OR bit 7 stuck at zero must be detected
    fault = 1'b1;
    pulse(1'b1);
    wait_done(1'b1, 400, n);
    chk("fault_sig", sig16, mf);
    chk("fault_pass", 32'(pass16), 32'd0);
    fault = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/alu_bist.md
ALU_BIST -- requirements
Module: alu_bist

Interface
REQ-001 Parameter NUM_VECTORS, 16, vectors applied per opcode (1..256).
REQ-002 Parameter LFSR_SEED, 32'hACE1_2468, LFSR load value at each start; nonzero.
REQ-003 Parameter GOLDEN_SIG, 32'h0000_0000, expected final MISR signature.
REQ-004 i_clk  input  1  single clock; all state on rising edge.
REQ-005 i_reset  input  1  asynchronous, active-high reset.
REQ-006 i_start  input  1  run request, sampled in IDLE and DONE only.
REQ-007 o_operand_a  output  32  drives the ALU i_operand_a.
REQ-008 o_operand_b  output  32  drives the ALU i_operand_b.
REQ-009 o_alu_op  output  4  drives the ALU i_alu_op.
REQ-010 i_alu_data  input  32  ALU o_alu_data, combinational from the three outputs above.
REQ-011 o_busy  output  1  high while a run is in progress.
REQ-012 o_done  output  1  high from run completion until next accepted start or reset.
REQ-013 o_pass  output  1  valid when o_done; high iff final signature equals GOLDEN_SIG.
REQ-014 o_signature  output  32  current MISR contents.
REQ-015 All outputs SHALL be registered.

Function
REQ-016 FSM states SHALL be IDLE, SEED, APPLY, SAMPLE, DONE.
REQ-017 IDLE or DONE with i_start=1 SHALL go to SEED next cycle; o_done, o_pass clear on that edge.
REQ-018 SEED (one cycle) SHALL load LFSR with LFSR_SEED, MISR with 32'hFFFF_FFFF, opcode index 0, vector count 0, then go to APPLY.
REQ-019 Opcode index SHALL step through, in order: 0000, 1000, 0001, 0010, 0011, 0100, 0101, 1101, 0110, 0111, 1111 (11 ops); no other encodings SHALL be driven.
REQ-020 APPLY SHALL present o_operand_a = LFSR state, o_operand_b = {LFSR[15:0], LFSR[31:16]}, o_alu_op = current opcode; go to SAMPLE.
REQ-021 Operands and opcode SHALL stay stable through APPLY and SAMPLE.
REQ-022 At the SAMPLE-ending edge the MISR SHALL update: t = sig[31] ? ((sig<<1) ^ 32'h04C1_1DB7) : (sig<<1); sig = t ^ i_alu_data.
REQ-023 LFSR SHALL be 32-bit Galois, shift right, feedback mask 32'h8020_0003 when bit 0 is 1; it advances once per vector, at the SAMPLE-ending edge.
REQ-024 Vector count wraps 0..NUM_VECTORS-1; on wrap opcode index increments; after last vector of opcode 1111 the FSM SHALL go to DONE, else APPLY.
REQ-025 LFSR SHALL NOT reload between opcodes; the sequence continues across ops.
REQ-026 Run length SHALL be exactly 1 + 22*NUM_VECTORS cycles from SEED entry to DONE entry.
REQ-027 DONE SHALL set o_done=1, o_busy=0, o_pass=(sig==GOLDEN_SIG); signature frozen until next start.
REQ-028 i_start during SEED/APPLY/SAMPLE SHALL be ignored.
REQ-029 In IDLE and DONE, o_operand_a=0, o_operand_b=0, o_alu_op=4'b0000.
REQ-030 o_busy SHALL be high in SEED, APPLY, SAMPLE.

Reset
REQ-031 i_reset asserted SHALL immediately force IDLE, o_busy=0, o_done=0, o_pass=0, o_signature=32'hFFFF_FFFF, operands 0, o_alu_op 0000, counters 0, LFSR=LFSR_SEED.
REQ-032 Reset mid-run SHALL abort with no completion indication; next start begins a full fresh run.

Verification
REQ-033 Reset: assert i_reset mid-cycle -> all outputs at REQ-031 values without waiting for a clock edge.
REQ-034 NUM_VECTORS=1, correct ALU model, one start pulse -> o_alu_op sequence matches REQ-019, first vector A=32'hACE1_2468, B=32'h2468_ACE1, o_done rises 23 cycles after start sampled, signature equals scoreboard model.
REQ-035 GOLDEN_SIG set to model signature, NUM_VECTORS=16 -> o_pass=1; ALU model with OR result bit 7 stuck-at-0 -> o_pass=0.
REQ-036 i_start held high throughout run -> single run only, length per REQ-026; new run starts the cycle after DONE is entered.
REQ-037 Reset asserted during opcode 0101 SAMPLE, then start -> full run, signature identical to an uninterrupted run.
REQ-038 Two back-to-back runs from DONE -> identical o_signature and o_pass.
